// File: rtl/bcp_pkg.sv
// Shared types and width defaults for the BCP clause-index encoder.
// Width defaults come from the BCP_CLAUSE_NUM / BCP_CLAUSE_NUM_LOG macros.
`ifndef BCP_CLAUSE_NUM
`define BCP_CLAUSE_NUM 8
`endif
`ifndef BCP_CLAUSE_NUM_LOG
`define BCP_CLAUSE_NUM_LOG 3
`endif

package bcp_pkg;

  localparam int CLAUSE_NUM_DEF = `BCP_CLAUSE_NUM;
  localparam int IDX_W_DEF      = `BCP_CLAUSE_NUM_LOG;
  localparam int CNT_W_DEF      = `BCP_CLAUSE_NUM_LOG + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } bcp_state_e;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Lowest-set-bit priority encoder.
// Reports the index of the lowest set bit and whether any bit is set.
module lsb_priority_encoder #(
  parameter int W     = 8,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcp_clause_encoder.sv
// Sequential clause-index encoder: snapshots a flag vector and
// streams out the indices of its set bits, lowest first.
module bcp_clause_encoder
  import bcp_pkg::*;
#(
  parameter int CLAUSE_NUM = CLAUSE_NUM_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vec_valid,
  input  logic [CLAUSE_NUM-1:0] vec_in,
  output logic                  vec_ready,
  input  logic                  flush,
  output logic                  idx_valid,
  output logic [IDX_W-1:0]      idx_out,
  input  logic                  idx_ready,
  output logic                  done,
  output logic [IDX_W:0]        count_out
);

  bcp_state_e state_q, state_d;

  logic [CLAUSE_NUM-1:0] pending_q, pending_d;
  logic [IDX_W:0]        count_q, count_d;

  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_any;
  logic [CLAUSE_NUM-1:0] cur_mask;
  logic [CLAUSE_NUM-1:0] pending_clr;
  logic                  rest_any;
  logic [IDX_W-1:0]      unused_rest_idx;

  lsb_priority_encoder #(
    .W     (CLAUSE_NUM),
    .IDX_W (IDX_W)
  ) u_cur (
    .vec_i (pending_q),
    .idx_o (cur_idx),
    .any_o (cur_any)
  );

  assign cur_mask    = {{(CLAUSE_NUM-1){1'b0}}, 1'b1} << cur_idx;
  assign pending_clr = pending_q & ~cur_mask;

  // Nothing left after clearing the current bit: this accept is the last.
  lsb_priority_encoder #(
    .W     (CLAUSE_NUM),
    .IDX_W (IDX_W)
  ) u_rest (
    .vec_i (pending_clr),
    .idx_o (unused_rest_idx),
    .any_o (rest_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (vec_valid) begin
            pending_d = vec_in;
            count_d   = '0;
            state_d   = (|vec_in) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (idx_valid && idx_ready) begin
            pending_d = pending_clr;
            count_d   = count_q + (IDX_W+1)'(1);
            if (!rest_any) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    vec_ready = 1'b0;
    idx_valid = 1'b0;
    idx_out   = '0;
    done      = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): vec_ready = 1'b1;
      (state_q == SCAN): begin
        idx_valid = cur_any;
        idx_out   = cur_any ? cur_idx : '0;
      end
      (state_q == DONE): done = 1'b1;
      default: ;
    endcase
  end

  assign count_out = count_q;

endmodule

// File: tb/tb_bcp_clause_encoder.sv
// Bench for bcp_clause_encoder: queue-based reference model,
// directed scenarios with literal pins, then randomized traffic.
module tb_bcp_clause_encoder;

  localparam int CN = 8;
  localparam int IW = 3;

  localparam int M_IDLE = 0;
  localparam int M_SCAN = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vec_valid;
  logic [CN-1:0] vec_in;
  logic          vec_ready;
  logic          flush;
  logic          idx_valid;
  logic [IW-1:0] idx_out;
  logic          idx_ready;
  logic          done;
  logic [IW:0]   count_out;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  int mq[$];
  int m_mode;
  int m_count;

  always #5 clk = ~clk;

  bcp_clause_encoder #(
    .CLAUSE_NUM (CN),
    .IDX_W      (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vec_valid (vec_valid),
    .vec_in    (vec_in),
    .vec_ready (vec_ready),
    .flush     (flush),
    .idx_valid (idx_valid),
    .idx_out   (idx_out),
    .idx_ready (idx_ready),
    .done      (done),
    .count_out (count_out)
  );

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode  = M_IDLE;
    m_count = 0;
  endtask

  // Reference behaviour at a rising edge, from the current inputs.
  task automatic model_edge();
    if (!rst_n) return;
    if (flush) begin
      m_mode = M_IDLE;
      mq.delete();
    end else if (m_mode == M_IDLE) begin
      if (vec_valid) begin
        mq.delete();
        for (int i = 0; i < CN; i++)
          if (vec_in[i]) mq.push_back(i);
        m_count = 0;
        m_mode  = (mq.size() > 0) ? M_SCAN : M_DONE;
      end
    end else if (m_mode == M_SCAN) begin
      if (idx_ready) begin
        void'(mq.pop_front());
        m_count++;
        if (mq.size() == 0) m_mode = M_DONE;
      end
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("vec_ready", int'(vec_ready), int'(m_mode == M_IDLE));
      chk("idx_valid", int'(idx_valid), int'(m_mode == M_SCAN));
      chk("idx_out", int'(idx_out),
          (m_mode == M_SCAN && mq.size() > 0) ? mq[0] : 0);
      chk("done", int'(done), int'(m_mode == M_DONE));
      chk("count_out", int'(count_out), m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  initial begin
    rst_n     = 1'b0;
    vec_valid = 1'b0;
    flush     = 1'b0;
    idx_ready = 1'b0;
    vec_in    = '0;
    model_reset();
    #12;
    chk("rst_vec_ready", int'(vec_ready), 1);
    chk("rst_idx_valid", int'(idx_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count_out), 0);
    started = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    // bits {0,3,5}
    vec_valid = 1'b1;
    vec_in    = 8'h29;
    idx_ready = 1'b1;
    step();
    vec_valid = 1'b0;
    chk("t1_idx0", int'(idx_out), 0);
    chk("t1_val0", int'(idx_valid), 1);
    step();
    chk("t1_idx1", int'(idx_out), 3);
    step();
    chk("t1_idx2", int'(idx_out), 5);
    step();
    chk("t1_done", int'(done), 1);
    chk("t1_count", int'(count_out), 3);
    step();
    chk("t1_ready", int'(vec_ready), 1);
    chk("t1_done_off", int'(done), 0);

    // zero vector
    vec_valid = 1'b1;
    vec_in    = 8'h00;
    step();
    vec_valid = 1'b0;
    chk("t2_done", int'(done), 1);
    chk("t2_val", int'(idx_valid), 0);
    chk("t2_count", int'(count_out), 0);
    step();
    chk("t2_ready", int'(vec_ready), 1);

    // bits {2,7} with backpressure, capture attempts while busy
    vec_valid = 1'b1;
    vec_in    = 8'h84;
    idx_ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      vec_valid = 1'b1;
      vec_in    = 8'hFF;
      chk("t3_hold_idx", int'(idx_out), 2);
      chk("t3_hold_val", int'(idx_valid), 1);
      chk("t3_busy", int'(vec_ready), 0);
      step();
    end
    vec_valid = 1'b0;
    idx_ready = 1'b1;
    chk("t3_idx0", int'(idx_out), 2);
    step();
    chk("t3_idx1", int'(idx_out), 7);
    step();
    chk("t3_done", int'(done), 1);
    chk("t3_count", int'(count_out), 2);
    step();

    // all bits set
    vec_valid = 1'b1;
    vec_in    = 8'hFF;
    step();
    vec_valid = 1'b0;
    for (int i = 0; i < CN; i++) begin
      chk("t4_idx", int'(idx_out), i);
      step();
    end
    chk("t4_done", int'(done), 1);
    chk("t4_count", int'(count_out), CN);
    step();

    // bits {1,4,6}, flush on the cycle index 4 is handshaken
    vec_valid = 1'b1;
    vec_in    = 8'h52;
    step();
    vec_valid = 1'b0;
    chk("t5_idx0", int'(idx_out), 1);
    step();
    chk("t5_idx1", int'(idx_out), 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_ready", int'(vec_ready), 1);
    chk("t5_val", int'(idx_valid), 0);
    chk("t5_nodone", int'(done), 0);
    chk("t5_count", int'(count_out), 1);
    step();
    chk("t5_nodone2", int'(done), 0);
    vec_valid = 1'b1;
    vec_in    = 8'h08;
    step();
    vec_valid = 1'b0;
    chk("t5_recap", int'(idx_out), 3);
    step();
    chk("t5_redone", int'(done), 1);
    chk("t5_recount", int'(count_out), 1);
    step();

    // asynchronous reset mid-scan
    vec_valid = 1'b1;
    vec_in    = 8'hFF;
    step();
    vec_valid = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_ready", int'(vec_ready), 1);
    chk("t6_val", int'(idx_valid), 0);
    chk("t6_idx", int'(idx_out), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_count", int'(count_out), 0);
    step();
    rst_n = 1'b1;
    step();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      vec_valid = ($urandom_range(0, 2) == 0);
      vec_in    = ($urandom_range(0, 7) == 0) ? '0 : CN'($urandom);
      idx_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    vec_valid = 1'b0;
    flush     = 1'b0;
    idx_ready = 1'b1;
    for (int c = 0; c < CN + 4; c++) step();

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
